pipe_skid_reg: RTL and testbench

- Elastic pipeline register with a valid/ready handshake on both sides and a 2-entry skid buffer.
- Successor to the plain enable/reset flop: handles backpressure without combinational ready paths, and adds flush and occupancy.
- Sits between processor pipeline stages (e.g. IF/ID, ID/EX) where the downstream stage can stall and branch/exception logic must squash in-flight contents.

---
 rtl/pipe_skid_reg.sv | 98 +++++++++
 tb/tb_pipe_skid_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic pipeline register with a two-entry skid buffer.
// Both handshake outputs come straight from flops, so there is no
// combinational path from out_ready or in_valid to any output.
// A flush empties the block, keeping the data registers as they are.
module pipe_skid_reg #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // The state encoding is the occupancy, so count is the state register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, out_valid_q;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Next-state and data steering. Flush wins over every transition.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State, data and flop-driven handshake outputs; reset dominates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: directed scenarios followed by a long random
// stall run, all checked against a queue-based model of the block.
module tb_pipe_skid_reg;

  localparam int          WIDTH = 32;
  localparam logic [31:0] RV    = 32'h13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  count;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the held entries, oldest first.
  logic [31:0] q[$];
  bit          rv_known   = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] prev_data  = '0;
  bit          seq_on     = 1'b0;
  logic [31:0] seq_exp    = '0;
  int          accepted   = 0;
  int          delivered  = 0;
  bit          verbose    = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: check outputs against the model, drive inputs, advance model.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] id, input logic ordy);
    bit m_ready, m_valid, in_f, out_f;
    m_ready = (q.size() < 2);
    m_valid = (q.size() > 0);

    check_val("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check_val("in_ready",  {31'd0, in_ready},  {31'd0, m_ready});
    check_val("count",     {30'd0, count},     32'(q.size()));
    if (m_valid)
      check_val("out_data", out_data, q[0]);
    else if (rv_known)
      check_val("out_data_rst", out_data, RV);
    if (stall_prev)
      check_val("stable", out_data, prev_data);
    if (seq_on)
      check_val("acc_minus_del", {30'd0, count}, 32'(accepted - delivered));

    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;

    in_f  = iv & m_ready & !r;
    out_f = m_valid & ordy & !r;

    if (out_f && seq_on) begin
      check_val("seq", out_data, seq_exp);
      seq_exp++;
    end
    if (out_f && verbose)
      $display("deliver data=%h%s", q[0], f ? " (with flush)" : "");
    if (in_f && verbose)
      $display("accept  data=%h%s", id, f ? " (discarded by flush)" : "");

    stall_prev = m_valid & !ordy & !r & !f;
    prev_data  = out_data;

    @(posedge clk);

    if (r) begin
      q.delete();
      rv_known = 1'b1;
      stall_prev = 1'b0;
    end else if (f) begin
      if (out_f) delivered++;
      if (in_f) accepted++;
      q.delete();
    end else begin
      if (out_f) begin
        void'(q.pop_front());
        delivered++;
      end
      if (in_f) begin
        q.push_back(id);
        accepted++;
        rv_known = 1'b0;
      end
    end

    @(negedge clk);
  endtask

  initial begin
    // Reset held two cycles with a live upstream transfer offered.
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hAAAA_AAAA; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rv_known = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Streaming with out_ready high.
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b1, 32'(i), 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Backpressure fill, then drain in order.
    step(1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Flush while full, then a fresh payload.
    step(1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h30, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Flush together with both handshakes while holding one entry.
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    delivered = 0;
    step(1'b0, 1'b1, 1'b1, 32'h50, 1'b1);
    check_val("flush_delivered", 32'(delivered), 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Mid-run reset while full.
    step(1'b0, 1'b0, 1'b1, 32'h60, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h70, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Random stall with an incrementing payload.
    verbose   = 1'b0;
    accepted  = 0;
    delivered = 0;
    seq_exp   = 32'h1000;
    seq_on    = 1'b1;
    begin
      logic [31:0] pay;
      pay = 32'h1000;
      for (int c = 0; c < 10000; c++) begin
        logic iv, ordy;
        iv   = ($urandom_range(0, 1) == 1);
        ordy = ($urandom_range(0, 1) == 1);
        step(1'b0, 1'b0, iv, iv ? pay : $urandom, ordy);
        if (iv && (q.size() > 0) && (q[q.size()-1] == pay)) pay++;
      end
      // Drain what is left.
      for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check_val("all_delivered", 32'(delivered), 32'(accepted));
      check_val("seq_end", seq_exp, pay);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
